seq_monitor: RTL

SEQ_MONITOR -- requirements
Module: seq_monitor

---
 rtl/seq_monitor_pkg.sv | 25 ++
 rtl/sat_cnt8.sv | 35 +++
 rtl/seq_monitor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seq_monitor_pkg.sv
// seq_monitor_pkg: shared types and constants for the sequence monitor.
//   state_e         - monitor FSM states (SEARCH / LOCKED / LOST)
//   LOCK_N_DEFAULT  - default consecutive matches needed to lock
//   LOSS_N_DEFAULT  - default consecutive mismatches needed to lose lock
//   CNT_W           - width of the event counters
//   RUN_W           - width of the good/bad run counters (holds 1..15)
//   next_count()    - expected successor of a 3-bit count (mod 8)
package seq_monitor_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } state_e;

    localparam int unsigned LOCK_N_DEFAULT = 4;
    localparam int unsigned LOSS_N_DEFAULT = 2;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned RUN_W          = 4;

    function automatic logic [2:0] next_count(input logic [2:0] value);
        return value + 3'd1;
    endfunction

endpackage

// File: rtl/sat_cnt8.sv
// sat_cnt8: 8-bit event counter.
//   clk, reset - clock, asynchronous active-high reset
//   i_clr      - synchronous clear (wins over i_inc)
//   i_inc      - count one event
//   i_sat      - 1: hold at 255, 0: wrap 255 -> 0
//   o_cnt      - current count
module sat_cnt8
    import seq_monitor_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_sat,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !(i_sat && w_at_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_monitor.sv
// seq_monitor: watches a 3-bit upstream counter and tracks whether it is
// counting cleanly (+1 mod 8 per valid sample).
//   clk, reset   - clock, asynchronous active-high reset
//   i_clr        - synchronous clear of FSM, history and counters
//   i_valid      - i_din carries a sample this cycle
//   i_din        - 3-bit count value
//   o_locked     - FSM in LOCKED
//   o_lost       - FSM in LOST
//   o_err_pulse  - one-cycle pulse per mismatch seen in LOCKED
//   o_wrap_pulse - one-cycle pulse per correct 7->0 transition (any state)
//   o_err_cnt    - saturating count of LOCKED mismatches
//   o_wrap_cnt   - modulo-256 count of correct wraps seen in LOCKED
module seq_monitor
    import seq_monitor_pkg::*;
#(
    parameter int unsigned LOCK_N = LOCK_N_DEFAULT,
    parameter int unsigned LOSS_N = LOSS_N_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic [2:0]       i_din,
    output logic             o_locked,
    output logic             o_lost,
    output logic             o_err_pulse,
    output logic             o_wrap_pulse,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_wrap_cnt
);

    state_e           r_state;
    state_e           w_state_next;
    logic [2:0]       r_prev;
    logic             r_prev_ok;
    logic [RUN_W-1:0] r_good_run;
    logic [RUN_W-1:0] w_good_next;
    logic [RUN_W-1:0] r_bad_run;
    logic [RUN_W-1:0] w_bad_next;
    logic             r_err_pulse;
    logic             r_wrap_pulse;

    logic             w_sample;
    logic             w_match;
    logic             w_mismatch;
    logic             w_wrap;
    logic             w_good_done;
    logic             w_bad_done;

    // clr discards any sample on the same edge.
    assign w_sample    = i_valid & ~i_clr;
    // Without history (first sample after reset/clr) a sample is neither match nor mismatch.
    assign w_match     = w_sample & r_prev_ok & (i_din == next_count(r_prev));
    assign w_mismatch  = w_sample & r_prev_ok & (i_din != next_count(r_prev));
    assign w_wrap      = w_match & (i_din == 3'd0);
    assign w_good_done = ({{(32 - RUN_W){1'b0}}, r_good_run} + 32'd1) >= LOCK_N;
    assign w_bad_done  = ({{(32 - RUN_W){1'b0}}, r_bad_run} + 32'd1) >= LOSS_N;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SEARCH;
            r_good_run <= '0;
            r_bad_run  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_good_run <= w_good_next;
            r_bad_run  <= w_bad_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_run;
        w_bad_next   = r_bad_run;
        if (i_clr) begin
            w_state_next = SEARCH;
            w_good_next  = '0;
            w_bad_next   = '0;
        end else if (i_valid) begin
            unique case (r_state)
                SEARCH: begin
                    if (w_match) begin
                        if (w_good_done) begin
                            w_state_next = LOCKED;
                            w_good_next  = '0;
                        end else begin
                            w_good_next = r_good_run + 1'b1;
                        end
                    end else if (w_mismatch) begin
                        w_good_next = '0;
                    end
                end
                LOCKED: begin
                    if (w_mismatch) begin
                        if (w_bad_done) begin
                            w_state_next = LOST;
                            w_bad_next   = '0;
                        end else begin
                            w_bad_next = r_bad_run + 1'b1;
                        end
                    end else if (w_match) begin
                        w_bad_next = '0;
                    end
                end
                LOST: begin
                    // Any sample leaves LOST; a match already counts toward relock.
                    w_state_next = SEARCH;
                    w_good_next  = w_match ? {{(RUN_W - 1){1'b0}}, 1'b1} : '0;
                end
                default: begin
                    w_state_next = SEARCH;
                    w_good_next  = '0;
                    w_bad_next   = '0;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_locked     = 1'b0;
        o_lost       = 1'b0;
        o_err_pulse  = r_err_pulse;
        o_wrap_pulse = r_wrap_pulse;
        if (r_state == LOCKED) begin
            o_locked = 1'b1;
        end
        if (r_state == LOST) begin
            o_lost = 1'b1;
        end
    end

    // Sample history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev    <= 3'd0;
            r_prev_ok <= 1'b0;
        end else if (i_clr) begin
            r_prev    <= 3'd0;
            r_prev_ok <= 1'b0;
        end else if (i_valid) begin
            r_prev    <= i_din;
            r_prev_ok <= 1'b1;
        end
    end

    // Pulses: w_match/w_mismatch are already gated by valid and clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_err_pulse  <= (r_state == LOCKED) & w_mismatch;
            r_wrap_pulse <= w_wrap;
        end
    end

    sat_cnt8 u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (i_clr),
        .i_inc ((r_state == LOCKED) & w_mismatch),
        .i_sat (1'b1),
        .o_cnt (o_err_cnt)
    );

    sat_cnt8 u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (i_clr),
        .i_inc ((r_state == LOCKED) & w_wrap),
        .i_sat (1'b0),
        .o_cnt (o_wrap_cnt)
    );

endmodule
